// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared types, RV32I opcode/funct constants and the field encoder
// Optional build macro: ENC_RANGE_CHECK_EN (flag out-of-range immediates as errors)
package enc_pkg;

  // Opcode and funct3 values used by the encoder (mirrors constant_def.vh)
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_IMM  = 7'b0010011;
  localparam logic [6:0] OP_I_LOAD = 7'b0000011;
  localparam logic [6:0] OP_S      = 7'b0100011;
  localparam logic [6:0] OP_B      = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SRX    = 3'b101;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} enc_state_t;

  typedef struct packed {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } enc_req_t;

  typedef struct packed {
    logic [31:0] word;
    logic        bad;
  } enc_res_t;

  // Pack one field-level request into an RV32I word; bad marks an error-worthy request
  function automatic enc_res_t encode(input enc_req_t r);
    enc_res_t res;
    logic     shift;
    res.word = NOP;
    res.bad  = 1'b0;
    shift    = (r.op == OP_I_IMM) && ((r.f3 == F3_SLL) || (r.f3 == F3_SRX));
    case (r.op)
      OP_R: res.word = {r.f7, r.rs2, r.rs1, r.f3, r.rd, r.op};
      OP_I_IMM, OP_I_LOAD: begin
        if (shift) res.word = {r.f7, r.imm[4:0], r.rs1, r.f3, r.rd, r.op};
        else       res.word = {r.imm[11:0], r.rs1, r.f3, r.rd, r.op};
`ifdef ENC_RANGE_CHECK_EN
        if (shift) res.bad = (r.imm[31:5] != '0);
        else       res.bad = !((&r.imm[31:11]) || !(|r.imm[31:11]));
`endif
      end
      OP_S: begin
        res.word = {r.imm[11:5], r.rs2, r.rs1, r.f3, r.imm[4:0], r.op};
`ifdef ENC_RANGE_CHECK_EN
        res.bad = !((&r.imm[31:11]) || !(|r.imm[31:11]));
`endif
      end
      OP_B: begin
        res.word = {r.imm[12], r.imm[10:5], r.rs2, r.rs1, r.f3, r.imm[4:1], r.imm[11], r.op};
`ifdef ENC_RANGE_CHECK_EN
        res.bad = !((&r.imm[31:12]) || !(|r.imm[31:12])) || r.imm[0];
`endif
      end
      OP_LUI, OP_AUIPC: begin
        res.word = {r.imm[31:12], r.rd, r.op};
`ifdef ENC_RANGE_CHECK_EN
        res.bad = (r.imm[11:0] != '0);
`endif
      end
      default: begin
        res.word = NOP;
        res.bad  = 1'b1;
      end
    endcase
    return res;
  endfunction

endpackage

// File: rtl/enc_fifo2.sv
// rtl/enc_fifo2.sv - two-entry word FIFO between the encoder and the IMEM port
module enc_fifo2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem_q [2];
  logic         wr_q;
  logic         rd_q;
  logic [1:0]   cnt_q;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_q];
  assign full    = (cnt_q == 2'd2);
  assign empty   = (cnt_q == 2'd0);

  // Storage, pointers and occupancy; push and pop may coincide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din;
        wr_q        <= ~wr_q;
      end
      if (do_pop) rd_q <= ~rd_q;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 2'd1;
      else if (!do_push && do_pop) cnt_q <= cnt_q - 2'd1;
    end
  end

endmodule

// File: rtl/instr_encode_loader.sv
// rtl/instr_encode_loader.sv - RV32I instruction assembler and IMEM program loader
// Optional build macro: ENC_RANGE_CHECK_EN (see enc_pkg encoder)
module instr_encode_loader
  import enc_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_last,
  input  logic [6:0]        req_op,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [2:0]        req_f3,
  input  logic [6:0]        req_f7,
  input  logic [31:0]       req_imm,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              err
);

  enc_state_t        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  count_q;
  logic              err_q;
  enc_req_t          req;
  enc_res_t          enc;
  logic              accept;
  logic              wr_fire;
  logic              fifo_full;
  logic              fifo_empty;

  assign req.op  = req_op;
  assign req.rd  = req_rd;
  assign req.rs1 = req_rs1;
  assign req.rs2 = req_rs2;
  assign req.f3  = req_f3;
  assign req.f7  = req_f7;
  assign req.imm = req_imm;
  assign enc     = encode(req);

  assign req_ready = (state_q == LOAD) && !fifo_full;
  assign accept    = req_valid && req_ready;
  assign imem_we   = !fifo_empty;
  assign wr_fire   = imem_we && imem_ready;
  assign imem_addr = addr_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign count     = count_q;
  assign err       = err_q;

  enc_fifo2 #(.W(32)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .pop   (wr_fire),
    .din   (enc.word),
    .dout  (imem_wdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Session FSM plus write address, write counter and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (wr_fire) begin
        addr_q  <= addr_q + ADDR_W'(4);
        count_q <= count_q + CNT_W'(1);
      end
      if (accept && enc.bad) err_q <= 1'b1;
      case (state_q)
        IDLE: if (start) begin
          state_q <= LOAD;
          addr_q  <= base_addr;
          count_q <= '0;
          err_q   <= 1'b0;
        end
        LOAD:    if (accept && req_last) state_q <= DRAIN;
        DRAIN:   if (fifo_empty) state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
// tb/tb_instr_encode_loader.sv - self-checking bench for instr_encode_loader
module tb_instr_encode_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_last = 1'b0;
  logic [6:0]  req_op = '0;
  logic [4:0]  req_rd = '0, req_rs1 = '0, req_rs2 = '0;
  logic [2:0]  req_f3 = '0;
  logic [6:0]  req_f7 = '0;
  logic [31:0] req_imm = '0;
  logic        imem_we;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        busy, done, err;
  logic [15:0] count;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_word_q[$];
  logic [31:0] m_addr = '0;
  int          sess_n = 0;
  logic        exp_err = 1'b0;
  bit          rand_ready_en = 1'b0;

  always #5 clk = ~clk;

  instr_encode_loader #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .req_valid(req_valid), .req_ready(req_ready), .req_last(req_last),
    .req_op(req_op), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_f3(req_f3), .req_f7(req_f7), .req_imm(req_imm),
    .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done), .count(count), .err(err)
  );

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference encoder: fields placed by weight, straight from the RV32I formats
  function automatic logic [31:0] ref_encode(input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                                             input logic [2:0] f3, input logic [6:0] f7,
                                             input logic [31:0] imm, output logic bad);
    logic [31:0] common;
    bad    = 1'b0;
    common = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
    case (op)
      7'h33: return common | (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rd) << 7);
      7'h13: if (f3 == 3'd1 || f3 == 3'd5)
               return common | (32'(f7) << 25) | ((imm & 32'h1F) << 20) | (32'(rd) << 7);
             else
               return common | ((imm & 32'hFFF) << 20) | (32'(rd) << 7);
      7'h03: return common | ((imm & 32'hFFF) << 20) | (32'(rd) << 7);
      7'h23: return common | (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | ((imm & 32'h1F) << 7);
      7'h63: return common | (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                    | (32'(rs2) << 20) | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
      7'h37, 7'h17: return (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
      default: begin
        bad = 1'b1;
        return 32'h0000_0013;
      end
    endcase
  endfunction

  // Write monitor: every IMEM handshake must match the next expected (addr, word)
  always @(negedge clk) begin
    if (rst_n === 1'b1 && imem_we === 1'b1 && imem_ready === 1'b1) begin
      checks++;
      assert (exp_word_q.size() > 0) else begin
        failures++;
        $error("FAIL unexpected_write observed addr=%h data=%h expected none", imem_addr, imem_wdata);
      end
      if (exp_word_q.size() > 0) begin
        check32("wr_addr", imem_addr, exp_addr_q.pop_front());
        check32("wr_data", imem_wdata, exp_word_q.pop_front());
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (rand_ready_en) imem_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #800000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic start_sess(input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = b;
    @(posedge clk); #1;
    start = 1'b0;
    m_addr = b;
    sess_n = 0;
    exp_err = 1'b0;
    check32("start_busy", busy, 1);
    check32("start_count", count, 0);
    check32("start_err", err, 0);
    check32("start_ready", req_ready, 1);
  endtask

  task automatic send(input logic [6:0] op, input logic [4:0] rd, rs1, rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm, input logic last,
                      input logic [31:0] exp_word, input logic exp_bad);
    bit ok = 1'b0;
    req_valid = 1'b1; req_last = last; req_op = op; req_rd = rd; req_rs1 = rs1;
    req_rs2 = rs2; req_f3 = f3; req_f7 = f7; req_imm = imm;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        ok = 1'b1;
        @(posedge clk); #1;
        break;
      end
    end
    check32("accept_in_time", 32'(ok), 1);
    if (ok) begin
      exp_addr_q.push_back(m_addr);
      exp_word_q.push_back(exp_word);
      m_addr += 32'd4;
      sess_n++;
      exp_err |= exp_bad;
    end
    req_valid = 1'b0;
    req_last = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check32("done_seen", 32'(seen), 1);
    if (seen) begin
      check32("done_count", count, 32'(sess_n));
      check32("done_err", err, exp_err);
      check32("done_all_written", exp_word_q.size(), 0);
      @(negedge clk);
      check32("done_one_cycle", done, 0);
      check32("idle_busy", busy, 0);
    end
  endtask

  initial begin
    logic [31:0] w, imm;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic        bad, last;
    int          kind;

    // Reset state
    @(negedge clk);
    check32("rst_we", imem_we, 0);
    check32("rst_addr", imem_addr, 0);
    check32("rst_wdata", imem_wdata, 0);
    check32("rst_ready", req_ready, 0);
    check32("rst_busy", busy, 0);
    check32("rst_done", done, 0);
    check32("rst_count", count, 0);
    check32("rst_err", err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    imem_ready = 1'b1;

    // Single ADD
    start_sess(32'h100);
    send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0, 1'b1, 32'h002081B3, 1'b0);
    wait_done();

    // Mixed formats, plus a start pulse mid-session that must be ignored
    start_sess(32'h0);
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 1'b0, 32'hFFF00093, 1'b0);
    start = 1'b1; base_addr = 32'h900;
    @(posedge clk); #1;
    start = 1'b0;
    check32("ignored_start_busy", busy, 1);
    send(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b0, 32'h0020A423, 1'b0);
    send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b0, 32'h123452B7, 1'b0);
    send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC, 1'b0, 32'hFE208EE3, 1'b0);
    send(7'h13, 5'd4, 5'd1, 5'd0, 3'd5, 7'h20, 32'd3, 1'b1, 32'h4030D213, 1'b0);
    wait_done();

    // Unknown opcode writes a NOP and sets err; next start clears it
    start_sess(32'h500);
    send(7'h7F, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'h0, 1'b1, 32'h00000013, 1'b1);
    wait_done();
    start_sess(32'h600);
    send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0, 1'b1, 32'h002081B3, 1'b0);
    wait_done();

    // IMEM stall: two accepts fill the FIFO, the third waits, outputs hold
    imem_ready = 1'b0;
    start_sess(32'h200);
    send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0, 1'b0, 32'h002081B3, 1'b0);
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 1'b0, 32'hFFF00093, 1'b0);
    req_valid = 1'b1; req_last = 1'b1; req_op = 7'h37; req_rd = 5'd5; req_imm = 32'h12345000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check32("stall_ready", req_ready, 0);
      check32("stall_we", imem_we, 1);
      check32("stall_addr", imem_addr, 32'h200);
      check32("stall_wdata", imem_wdata, 32'h002081B3);
    end
    @(posedge clk); #1;
    imem_ready = 1'b1;
    send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b1, 32'h123452B7, 1'b0);
    wait_done();

    // Reset during DRAIN with a full FIFO, then a clean restart
    start_sess(32'h300);
    send(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0, 1'b0, 32'h002081B3, 1'b0);
    @(posedge clk); #1;
    imem_ready = 1'b0;
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 1'b0, 32'hFFF00093, 1'b0);
    send(7'h13, 5'd4, 5'd1, 5'd0, 3'd5, 7'h20, 32'd3, 1'b1, 32'h4030D213, 1'b0);
    @(negedge clk);
    check32("drain_busy", busy, 1);
    check32("drain_count", count, 1);
    check32("drain_ready", req_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_addr_q.delete();
    exp_word_q.delete();
    @(negedge clk);
    check32("midrst_we", imem_we, 0);
    check32("midrst_busy", busy, 0);
    check32("midrst_count", count, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    imem_ready = 1'b1;
    start_sess(32'h40);
    send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC, 1'b1, 32'hFE208EE3, 1'b0);
    wait_done();

    // Random program across the address wrap with random IMEM back-pressure
    rand_ready_en = 1'b1;
    start_sess(32'hFFFFFFF0);
    for (int n = 0; n < 24; n++) begin
      kind = $urandom_range(0, 8);
      f3 = 3'($urandom_range(0, 7));
      f7 = 7'($urandom_range(0, 127));
      imm = $urandom;
      case (kind)
        0: op = 7'h33;
        1: begin op = 7'h13; if (f3 == 3'd1 || f3 == 3'd5) f3 = 3'd0; imm = 32'($urandom_range(0, 4095)) - 32'd2048; end
        2: begin op = 7'h13; f3 = ($urandom_range(0, 1) != 0) ? 3'd1 : 3'd5;
                 f7 = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00; imm = 32'($urandom_range(0, 31)); end
        3: begin op = 7'h03; imm = 32'($urandom_range(0, 4095)) - 32'd2048; end
        4: begin op = 7'h23; imm = 32'($urandom_range(0, 4095)) - 32'd2048; end
        5: begin op = 7'h63; imm = (32'($urandom_range(0, 4095)) - 32'd2048) << 1; end
        6: begin op = 7'h37; imm = imm & 32'hFFFFF000; end
        7: begin op = 7'h17; imm = imm & 32'hFFFFF000; end
        default: op = 7'h7F;
      endcase
      last = (n == 23);
      w = ref_encode(op, 5'($urandom_range(0, 31)), 5'd7, 5'd9, f3, f7, imm, bad);
      send(op, 5'($urandom_range(0, 31)) & 5'd0 | w[11:7], 5'd7, 5'd9, f3, f7, imm, last, w, bad);
    end
    wait_done();
    rand_ready_en = 1'b0;
    @(posedge clk); #1;
    imem_ready = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
